// File: rtl/fir_xifu_wb.sv
// Writeback stage of the FIR XIFU pipeline.
// Takes the registered execute payload and, for loads, waits for the matching LSU result.
// It then writes the XIFU register file and returns the X-interface result to the core.
// The execute stage is held off via ready_o while a transaction is outstanding.
module fir_xifu_wb #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned NREGS      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  // execute-to-writeback payload
  input  logic                     ex_valid_i,
  input  logic [1:0]               ex_instr_i,
  input  logic [X_ID_WIDTH-1:0]    ex_id_i,
  input  logic [4:0]               ex_rd_i,
  input  logic [4:0]               ex_rs1_i,
  input  logic [31:0]              ex_result_i,
  output logic                     ready_o,
  // core LSU memory result
  input  logic                     mem_result_valid_i,
  input  logic [X_ID_WIDTH-1:0]    mem_result_id_i,
  input  logic [31:0]              mem_result_rdata_i,
  input  logic                     mem_result_err_i,
  // X-interface result
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [31:0]              result_data_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic                     result_exc_o,
  // XIFU register-file write port
  output logic                     rf_we_o,
  output logic [$clog2(NREGS)-1:0] rf_waddr_o,
  output logic [31:0]              rf_wdata_o
);

  localparam int unsigned AddrW = $clog2(NREGS);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitMem = 2'd1;
  localparam logic [1:0] StWaitRes = 2'd2;

  localparam logic [1:0] InstrNone = 2'd0;
  localparam logic [1:0] InstrLw   = 2'd1;
  localparam logic [1:0] InstrSw   = 2'd2;
  localparam logic [1:0] InstrDotp = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            instr_q, instr_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d;
  logic [4:0]            rd_q, rd_d;
  logic [4:0]            rs1_q, rs1_d;
  logic [31:0]           res_q, res_d;
  logic                  err_q, err_d;
  logic                  rf_we_q, rf_we_d;
  logic [AddrW-1:0]      rf_waddr_q, rf_waddr_d;
  logic [31:0]           rf_wdata_q, rf_wdata_d;

  logic capture;
  logic mem_hit;
  logic is_lw;
  logic is_sw;
  logic is_dotp;

  // Accept a new payload when idle, or in the same cycle the pending result is handshaken.
  always_comb begin
    ready_o = (state_q == StIdle) | ((state_q == StWaitRes) & result_ready_i);
    capture = ex_valid_i & ready_o & (ex_instr_i != InstrNone);
    mem_hit = (state_q == StWaitMem) & mem_result_valid_i & (mem_result_id_i == id_q);
  end

  // Next-state logic: FSM transitions, payload capture and the one-cycle rf write pulse.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    id_d       = id_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    res_d      = res_q;
    err_d      = err_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    unique case (state_q)
      StIdle: begin
      end
      StWaitMem: begin
        // Results carrying another id belong to someone else and are ignored.
        if (mem_hit) begin
          state_d    = StWaitRes;
          err_d      = mem_result_err_i;
          rf_we_d    = ~mem_result_err_i;
          rf_waddr_d = rd_q[AddrW-1:0];
          rf_wdata_d = mem_result_rdata_i;
        end
      end
      StWaitRes: begin
        if (result_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Capture overrides the handshake-to-idle transition for back-to-back issue.
    if (capture) begin
      instr_d = ex_instr_i;
      id_d    = ex_id_i;
      rd_d    = ex_rd_i;
      rs1_d   = ex_rs1_i;
      res_d   = ex_result_i;
      err_d   = 1'b0;
      state_d = (ex_instr_i == InstrLw) ? StWaitMem : StWaitRes;
      if (ex_instr_i == InstrDotp) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = ex_rd_i[AddrW-1:0];
        rf_wdata_d = ex_result_i;
      end
    end
  end

  // State registers; clear flushes everything like reset, dropping any pending instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      instr_q    <= InstrNone;
      id_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (clear_i) begin
      state_q    <= StIdle;
      instr_q    <= InstrNone;
      id_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      id_q       <= id_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      res_q      <= res_d;
      err_q      <= err_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Result fields come straight from latched state so they hold stable while stalled.
  always_comb begin
    is_lw   = (instr_q == InstrLw);
    is_sw   = (instr_q == InstrSw);
    is_dotp = (instr_q == InstrDotp);

    result_valid_o = (state_q == StWaitRes);
    result_id_o    = id_q;
    result_data_o  = res_q;
    // Loads/stores post-increment the core base register; dot-products report their rd.
    result_rd_o    = is_dotp ? rd_q : rs1_q;
    result_we_o    = result_valid_o & ((is_lw & ~err_q) | is_sw);
    result_exc_o   = result_valid_o & is_lw & err_q;

    rf_we_o    = rf_we_q;
    rf_waddr_o = rf_waddr_q;
    rf_wdata_o = rf_wdata_q;
  end

endmodule
